// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the configuration-register slave.
// Provides the response type, the two response codes used by this block
// and the byte-strobe width of the 32-bit data bus.
package axil_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  localparam int STRB_WIDTH = 4;

endpackage

// File: rtl/axil_confreg_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid and ready are both 1; the source holds payload and valid stable until
// that edge, and ready may depend on the sink's state but never on valid.
// Modports: master (initiator side), slave (responder side).
interface axil_confreg_slave_if #(
  parameter int ADDR_WIDTH = 4
);
  import axil_pkg::*;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  axi_resp_t             bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  axi_resp_t             rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_skid_slot.sv
// One-deep valid/ready holding register.
// Ports: clock, reset (async, active-high); in_valid/in_ready/in_data accept
// one item when empty; full/data present the held item; clear empties the slot.
// The slot only loads while empty, so load and clear never coincide.
module axil_skid_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign in_ready = !full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_confreg_slave.sv
// AXI4-Lite responder with NUM_REGS 32-bit read/write configuration registers.
// Ports: clock, reset (async, active-high); s_axi (AXI4-Lite slave bundle);
// cfg_regs (register i at [32*i +: 32]); cfg_wr_pulse (one-cycle pulse after
// register i is committed, even for an all-zero strobe).
// AW and W are buffered in independent one-deep slots; a write commits once
// both are held and the B channel is free (or retiring on the same edge).
module axil_confreg_slave
  import axil_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  axil_confreg_slave_if.slave            s_axi,
  output logic [DATA_WIDTH*NUM_REGS-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]            cfg_wr_pulse
);

  localparam int IW = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                               aw_full, w_full, aw_ready, w_ready;
  logic [ADDR_WIDTH-1:0]              aw_addr;
  logic [STRB_WIDTH+DATA_WIDTH-1:0]   w_bundle;
  logic [DATA_WIDTH-1:0]              w_data;
  logic [STRB_WIDTH-1:0]              w_strb;
  logic [IW-1:0]                      aw_idx, ar_idx;
  logic                               aw_hit, ar_hit, commit;
  logic                               bvalid_q, rvalid_q;
  axi_resp_t                          bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]              rdata_q, rd_word;
  logic                               unused_ok;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_WIDTH; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  axil_skid_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (s_axi.awvalid),
    .in_ready (aw_ready),
    .in_data  (s_axi.awaddr),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axil_skid_slot #(.WIDTH(STRB_WIDTH+DATA_WIDTH)) u_w_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (s_axi.wvalid),
    .in_ready (w_ready),
    .in_data  ({s_axi.wstrb, s_axi.wdata}),
    .clear    (commit),
    .full     (w_full),
    .data     (w_bundle)
  );

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign {w_strb, w_data} = w_bundle;

  assign aw_idx = aw_addr[ADDR_WIDTH-1:2];
  assign ar_idx = s_axi.araddr[ADDR_WIDTH-1:2];
  assign aw_hit = int'(aw_idx) < NUM_REGS;
  assign ar_hit = int'(ar_idx) < NUM_REGS;

  // A pending response that retires on this edge frees B for the next commit.
  assign commit = aw_full && w_full && (!bvalid_q || s_axi.bready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      cfg_wr_pulse <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
    end else begin
      cfg_wr_pulse <= '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_hit && int'(aw_idx) == i) begin
            regs[i]         <= merge(regs[i], w_data, w_strb);
            cfg_wr_pulse[i] <= 1'b1;
          end
        end
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(ar_idx) == i) rd_word = regs[i];
  end

  assign s_axi.arready = !rvalid_q || s_axi.rready;

  // Read data is sampled from the pre-edge register value, so a read that
  // coincides with a write to the same register returns the old contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axi.arvalid && s_axi.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_hit ? rd_word : '0;
      rresp_q  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_regs[DATA_WIDTH*g +: DATA_WIDTH] = regs[g];
  end

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, aw_addr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_axil_confreg_slave.sv
// Self-checking bench for axil_confreg_slave: directed scenarios followed by
// randomized traffic, all checked against a register-array reference model.
module tb_axil_confreg_slave;
  import axil_pkg::*;

  localparam int NUM_REGS   = 4;
  localparam int ADDR_WIDTH = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [32*NUM_REGS-1:0] cfg_regs;
  logic [NUM_REGS-1:0]    cfg_wr_pulse;

  always #5 clock = ~clock;

  axil_confreg_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  axil_confreg_slave #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .s_axi        (bus.slave),
    .cfg_regs     (cfg_regs),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]         model_regs [NUM_REGS];
  logic [1:0]          exp_b_q [$];
  logic [33:0]         exp_r_q [$];
  logic [NUM_REGS-1:0] exp_p_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  // ---------------- ready drivers ----------------
  logic rnd_ready   = 1'b0;
  logic bready_hold = 1'b1;
  logic rready_hold = 1'b1;

  always @(posedge clock) begin
    #2;
    bus.bready = rnd_ready ? 1'($urandom_range(0, 1)) : bready_hold;
    bus.rready = rnd_ready ? 1'($urandom_range(0, 1)) : rready_hold;
  end

  // Response monitor: a beat seen with valid&&ready at the negedge transfers
  // on the following rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", bus.bresp, exp_b_q.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          logic [33:0] e;
          e = exp_r_q.pop_front();
          check("rresp", bus.rresp, e[33:32]);
          check("rdata", bus.rdata, e[31:0]);
        end
      end
      if (cfg_wr_pulse != '0) begin
        if (exp_p_q.size() == 0) check("pulse_unexpected", cfg_wr_pulse, 0);
        else check("cfg_wr_pulse", cfg_wr_pulse, exp_p_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_aw(input logic [ADDR_WIDTH-1:0] a, input int delay);
    logic hs;
    int   n;
    repeat (delay) begin @(posedge clock); #1; end
    bus.awaddr  = a;
    bus.awprot  = 3'($urandom_range(0, 7));
    bus.awvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 100) begin
      @(negedge clock); hs = bus.awready;
      @(posedge clock); #1; n++;
    end
    bus.awvalid = 1'b0;
    if (!hs) check("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int delay);
    logic hs;
    int   n;
    repeat (delay) begin @(posedge clock); #1; end
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 100) begin
      @(negedge clock); hs = bus.wready;
      @(posedge clock); #1; n++;
    end
    bus.wvalid = 1'b0;
    if (!hs) check("w_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [ADDR_WIDTH-1:0] a, output int cycles);
    logic hs;
    bus.araddr  = a;
    bus.arprot  = 3'($urandom_range(0, 7));
    bus.arvalid = 1'b1;
    hs     = 1'b0;
    cycles = 0;
    while (!hs && cycles < 100) begin
      @(negedge clock); hs = bus.arready;
      @(posedge clock); #1; cycles++;
    end
    bus.arvalid = 1'b0;
    if (!hs) check("ar_timeout", 0, 1);
  endtask

  task automatic write_txn(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly);
    int idx;
    idx = int'(a) / 4;
    if (idx < NUM_REGS) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
      exp_b_q.push_back(RESP_OKAY);
      exp_p_q.push_back(NUM_REGS'(1) << idx);
    end else begin
      exp_b_q.push_back(RESP_SLVERR);
    end
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
  endtask

  task automatic read_txn(input logic [ADDR_WIDTH-1:0] a, output int cycles);
    int idx;
    idx = int'(a) / 4;
    if (idx < NUM_REGS) exp_r_q.push_back({RESP_OKAY, model_regs[idx]});
    else                exp_r_q.push_back({RESP_SLVERR, 32'h0});
    send_ar(a, cycles);
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (exp_b_q.size() != 0 && n < 300) begin @(posedge clock); #1; n++; end
    if (exp_b_q.size() != 0) check("b_drain_timeout", exp_b_q.size(), 0);
  endtask

  task automatic wait_r_done();
    int n = 0;
    while (exp_r_q.size() != 0 && n < 300) begin @(posedge clock); #1; n++; end
    if (exp_r_q.size() != 0) check("r_drain_timeout", exp_r_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [127:0] snap;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, RESP_OKAY);
    check("rst_rresp", bus.rresp, RESP_OKAY);
    check("rst_rdata", bus.rdata, 0);
    check("rst_cfg_regs", cfg_regs, 0);
    check("rst_pulse", cfg_wr_pulse, 0);
    @(posedge clock); #1;

    // 1: fill all registers, read back one per cycle
    for (int i = 0; i < NUM_REGS; i++) begin
      write_txn(ADDR_WIDTH'(4*i), 32'(i+1), 4'hF, 0, 0);
      wait_b_done();
    end
    check("t1_cfg_regs", cfg_regs, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < NUM_REGS; i++) begin
      read_txn(ADDR_WIDTH'(4*i), cyc);
      check("t1_read_cycles", cyc, 1);
    end
    wait_r_done();

    // 2: partial strobe merge
    write_txn(5'h00, 32'hAABBCCDD, 4'hF, 0, 0);
    wait_b_done();
    write_txn(5'h00, 32'h11223344, 4'b0101, 0, 0);
    wait_b_done();
    check("t2_merge", cfg_regs[31:0], 32'hAA22CC44);
    read_txn(5'h00, cyc);
    wait_r_done();

    // 3: W leads AW by 3 cycles
    fork
      write_txn(5'h04, 32'h5A5A5A5A, 4'hF, 3, 0);
      begin
        @(posedge clock); @(negedge clock);
        check("t3_wready_low", bus.wready, 0);
        check("t3_no_bvalid", bus.bvalid, 0);
      end
    join
    wait_b_done();
    check("t3_reg", cfg_regs[63:32], 32'h5A5A5A5A);
    read_txn(5'h04, cyc);
    wait_r_done();

    // 4: out-of-range write and read
    snap = model_flat();
    write_txn(5'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_b_done();
    read_txn(5'h14, cyc);
    wait_r_done();
    check("t4_unchanged", cfg_regs, snap);

    // 5: B backpressure with two writes queued
    bready_hold = 1'b0;
    write_txn(5'h18, 32'h01020304, 4'hF, 0, 0);
    snap = model_flat();
    write_txn(5'h08, 32'hCAFEF00D, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t5_bvalid_hold", bus.bvalid, 1);
      check("t5_bresp_hold", bus.bresp, RESP_SLVERR);
      check("t5_aw_blocked", bus.awready, 0);
      check("t5_no_commit", cfg_regs, snap);
    end
    @(posedge clock); #1;
    bready_hold = 1'b1;
    wait_b_done();
    check("t5_second_commit", cfg_regs, model_flat());

    // 6: reset with both responses pending
    bready_hold = 1'b0;
    rready_hold = 1'b0;
    write_txn(5'h0C, 32'h77777777, 4'hF, 0, 0);
    @(posedge clock); #1;
    read_txn(5'h04, cyc);
    @(negedge clock);
    check("t6_bvalid_pre", bus.bvalid, 1);
    check("t6_rvalid_pre", bus.rvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_bvalid_rst", bus.bvalid, 0);
    check("t6_rvalid_rst", bus.rvalid, 0);
    check("t6_cfg_rst", cfg_regs, 0);
    exp_b_q.delete();
    exp_r_q.delete();
    exp_p_q.delete();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    bready_hold = 1'b1;
    rready_hold = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < NUM_REGS; i++) read_txn(ADDR_WIDTH'(4*i), cyc);
    wait_r_done();

    // randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) < 2) begin
        write_txn(ADDR_WIDTH'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b_done();
      end else begin
        read_txn(ADDR_WIDTH'($urandom_range(0, 31)), cyc);
      end
    end
    wait_r_done();
    wait_b_done();
    rnd_ready = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    check("rand_cfg_regs", cfg_regs, model_flat());
    check("pulse_drain", exp_p_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
